// File: rtl/ps2_pkg.sv
// Shared types, constants and helpers for the PS/2 mouse receive path.
//   frame_state_t  : receive-frame FSM states
//   PS2_BYTE_W     : payload bits per PS/2 frame
//   SYNC..YO       : bit positions inside packet byte 0
//   timeout_cycles : converts a microsecond timeout into system-clock cycles
//   sat_mag        : 9-bit two's complement -> saturated 8-bit magnitude
package ps2_pkg;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_state_t;

  localparam int unsigned PS2_BYTE_W = 8;

  localparam int unsigned SYNC = 3;
  localparam int unsigned XS   = 4;
  localparam int unsigned YS   = 5;
  localparam int unsigned XO   = 6;
  localparam int unsigned YO   = 7;

  function automatic int unsigned timeout_cycles(input int unsigned clk_freq_hz,
                                                 input int unsigned timeout_us);
    longint unsigned prod;
    prod = 64'(clk_freq_hz) * 64'(timeout_us);
    return 32'(prod / 64'd1_000_000);
  endfunction

  // Overflow flag forces full scale; -256 has no 8-bit magnitude and clips to 255.
  function automatic logic [7:0] sat_mag(input logic [8:0] v, input logic ovf);
    logic [8:0] neg;
    neg = 9'd0 - v;
    if (ovf) return 8'hFF;
    if (!v[8]) return v[7:0];
    if (neg[8]) return 8'hFF;
    return neg[7:0];
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises and glitch-filters the raw bus, strobes on
// each filtered clock falling edge and deserialises one 11-bit frame.
//   clk, arst   : system clock, async active-high reset
//   ps2_clk     : raw PS/2 clock (asynchronous)
//   ps2_data    : raw PS/2 data (asynchronous)
//   flush       : abandon the current frame (inter-edge timeout)
//   strobe      : one-cycle pulse per filtered PS/2 clock falling edge
//   data_byte   : received payload, valid alongside byte_valid
//   byte_valid  : frame completed with good parity and stop bit
//   frame_err   : frame completed with bad parity or stop bit
//   busy        : a frame is in progress
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  flush,
  output logic                  strobe,
  output logic [PS2_BYTE_W-1:0] data_byte,
  output logic                  byte_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic          filt_clk;
  logic [CW-1:0] filt_cnt;

  frame_state_t    state;
  logic [2:0]      bit_cnt;
  logic [PS2_BYTE_W-1:0] shreg;
  logic            parity_ok;

  // Idle bus is high, so the synchronisers and filter come out of reset at 1.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      strobe    <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
      strobe    <= 1'b0;
      if (clk_sync == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == CW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
        strobe   <= filt_clk;  // only the 1 -> 0 transition strobes
      end else begin
        filt_cnt <= filt_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= StIdle;
      bit_cnt   <= '0;
      shreg     <= '0;
      parity_ok <= 1'b0;
    end else if (flush) begin
      state <= StIdle;
    end else if (strobe) begin
      case (state)
        StIdle: begin
          if (!data_sync) begin
            state   <= StData;
            bit_cnt <= '0;
          end
        end
        StData: begin
          shreg   <= {data_sync, shreg[PS2_BYTE_W-1:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= StParity;
        end
        StParity: begin
          parity_ok <= ^{shreg, data_sync};
          state     <= StStop;
        end
        StStop:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Completion is flagged on the stop-bit strobe itself so the packet
  // registers in the top land one cycle later.
  assign data_byte  = shreg;
  assign byte_valid = strobe && (state == StStop) && parity_ok && data_sync;
  assign frame_err  = strobe && (state == StStop) && !(parity_ok && data_sync);
  assign busy       = (state != StIdle);

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse stream-mode decoder: assembles 3-byte packets from the frame
// receiver, supervises inter-edge gaps and presents saturated sign/magnitude
// movement.
//   clk, arst          : system clock, async active-high reset
//   i_ps2_clk/data     : raw PS/2 bus
//   o_mouse_x/y        : |dx|, |dy| saturated to 255
//   o_is_mouse_x/y_neg : movement sign
//   o_buttons          : {middle, right, left}
//   o_valid            : one-cycle pulse, new packet on outputs
//   o_error            : one-cycle pulse, frame or packet dropped
module ps2_mouse_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_US  = 200
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_mouse_x,
  output logic       o_is_mouse_x_neg,
  output logic [7:0] o_mouse_y,
  output logic       o_is_mouse_y_neg,
  output logic [2:0] o_buttons,
  output logic       o_valid,
  output logic       o_error
);

  localparam int unsigned TO_CYCLES = timeout_cycles(CLK_FREQ_HZ, TIMEOUT_US);

  logic [PS2_BYTE_W-1:0] rx_byte;
  logic                  strobe, byte_valid, frame_err, busy;
  logic                  active, expire;
  logic [1:0]            idx;
  logic [PS2_BYTE_W-1:0] b0, b1;
  logic [31:0]           to_cnt;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN)
  ) u_rx (
    .clk        (clk),
    .arst       (arst),
    .ps2_clk    (i_ps2_clk),
    .ps2_data   (i_ps2_data),
    .flush      (expire),
    .strobe     (strobe),
    .data_byte  (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // A strobe restarts the gap count, so it always wins over expiry.
  assign active = busy || (idx != 2'd0);
  assign expire = active && !strobe && (to_cnt == TO_CYCLES - 1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      to_cnt <= '0;
    end else if (strobe || !active || expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      idx              <= 2'd0;
      b0               <= '0;
      b1               <= '0;
      o_mouse_x        <= '0;
      o_is_mouse_x_neg <= 1'b0;
      o_mouse_y        <= '0;
      o_is_mouse_y_neg <= 1'b0;
      o_buttons        <= '0;
      o_valid          <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_error <= 1'b0;
      if (expire || frame_err) begin
        idx     <= 2'd0;
        o_error <= 1'b1;
      end else if (byte_valid) begin
        case (idx)
          2'd0: begin
            // Byte 0 always carries bit3 set; anything else means we are
            // mid-packet, so drop it and keep hunting.
            if (rx_byte[SYNC]) begin
              b0  <= rx_byte;
              idx <= 2'd1;
            end else begin
              o_error <= 1'b1;
            end
          end
          2'd1: begin
            b1  <= rx_byte;
            idx <= 2'd2;
          end
          default: begin
            idx              <= 2'd0;
            o_valid          <= 1'b1;
            o_mouse_x        <= sat_mag({b0[XS], b1}, b0[XO]);
            o_is_mouse_x_neg <= b0[XS];
            o_mouse_y        <= sat_mag({b0[YS], rx_byte}, b0[YO]);
            o_is_mouse_y_neg <= b0[YS];
            o_buttons        <= b0[2:0];
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_mouse_decoder.md
Name: ps2_mouse_decoder

Overview:
- Receive-only PS/2 mouse front end that feeds the console's mouse inputs: mouse_x, is_mouse_x_neg, mouse_y and is_mouse_y_neg.
- Synchronises and filters the raw PS/2 clock and data lines, deserialises 11-bit frames and assembles the 3-byte stream-mode packets.
- Converts the 9-bit two's-complement movement to saturated sign/magnitude form.
- Stream-mode enable (host command 0xF4) is issued by the board PS/2 wrapper and is out of scope here.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- FILTER_LEN, 8, cycles ps2_clk must hold a new level before the filtered clock changes.
- TIMEOUT_US, 200, maximum gap between PS/2 clock edges inside a frame or packet before resync.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- i_ps2_clk  in  1  raw PS/2 clock, asynchronous
- i_ps2_data  in  1  raw PS/2 data, asynchronous
- o_mouse_x  out  8  |dx|, saturated to 255
- o_is_mouse_x_neg  out  1  dx sign
- o_mouse_y  out  8  |dy|, saturated to 255
- o_is_mouse_y_neg  out  1  dy sign
- o_buttons  out  3  {middle, right, left}
- o_valid  out  1  one-cycle pulse, new packet on outputs
- o_error  out  1  one-cycle pulse, frame or packet dropped

Behaviour:
- Reset: clk/arst only; all asynchronous, active-high.
  - All outputs 0, FSM in IDLE, byte index 0, sync flops 1 (bus idle high).
  - Reset mid-frame discards everything.
- Input conditioning:
  - 2-flop synchroniser on both inputs.
  - The filtered clock changes only after FILTER_LEN consecutive identical samples.
  - A falling edge of the filtered clock produces a one-cycle strobe. Data is sampled from the synchronised data line on that strobe.
- Frame FSM (sub-module), states IDLE -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: on strobe with data=0 (start bit) go to DATA. A strobe with data=1 is ignored.
  - DATA: 8 strobes shift bits in LSB first.
  - PARITY: the sampled bit must make odd parity over the 8 data bits plus the parity bit.
  - STOP: the sampled bit must be 1. On the STOP strobe, emit byte_valid if parity and stop are correct, otherwise frame_err. Return to IDLE either way.
- Timeout:
  - Counter of TIMEOUT_US*CLK_FREQ_HZ/1e6 cycles, cleared on every strobe.
  - Active when the FSM is not in IDLE, or when the byte index is not 0.
  - On expiry: FSM -> IDLE, byte index -> 0, o_error pulses once.
- Packet assembly (byte index 0..2):
  - Byte 0 must have bit3 = 1. If not, drop it, keep index 0 and pulse o_error. This is the resync rule.
  - frame_err at any index: index -> 0, o_error pulse.
  - On byte 2 valid: index -> 0 and outputs are updated.
- Arithmetic on byte 2 completion:
  - dx = {b0[4], b1} as 9-bit signed; dy = {b0[5], b2}.
  - Sign output = bit 8.
  - Magnitude = |value|. -256 yields 255.
  - If X overflow b0[6] (Y overflow b0[7]) is set, the magnitude is forced to 255 and the sign is kept.
  - o_buttons = b0[2:0].
- Latency and hold:
  - Outputs register and o_valid pulses exactly 1 cycle after the stop-bit strobe of byte 2.
  - Outputs hold until the next valid packet; consumers sample on o_valid.
- Simultaneous events: a timeout and a strobe never coincide, because the strobe clears the counter first and therefore takes priority.
- o_valid and o_error are mutually exclusive in any cycle.

Decomposition:
- ps2_pkg:
  - frame state enum (IDLE, DATA, PARITY, STOP)
  - PS2_BYTE_W=8
  - packet byte-0 bit positions (SYNC=3, XS=4, YS=5, XO=6, YO=7)
  - function timeout_cycles(CLK_FREQ_HZ, TIMEOUT_US)
- Sub-module ps2_rx_frame:
  - Contents: synchroniser, filter, edge strobe, frame FSM.
  - Outputs: byte, byte_valid, frame_err, busy.
- Top level holds packet assembly, timeout, saturation and output registers.

Test Plan:
1. Packet 0x28, 0x05, 0xFD at 12.5 kHz PS/2 clock -> one o_valid. Outputs: mouse_x=5, x_neg=0, mouse_y=3, y_neg=1, buttons=0.
2. Packet 0x19 (XS=1), 0x00, 0x00 -> mouse_x=255, x_neg=1, mouse_y=0, y_neg=0, buttons=3'b001. Packet 0x48 (XO=1), 0x10, 0x00 -> mouse_x=255, x_neg=0.
3. Byte 1 sent with a flipped parity bit -> o_error pulses once, no o_valid. The next clean packet 0x08, 0x01, 0x01 decodes to x=1, y=1.
4. Stray byte 0x05 (bit3=0), then a packet 0x08, 0x02, 0x02 -> the first byte is dropped with an o_error pulse; o_valid follows with x=2, y=2.
5. Two bytes of a packet, then the bus idles 250 us -> exactly one o_error. A fresh packet 0x28, 0x01, 0xFF decodes to x=1, y=1, y_neg=1.
6. 2-cycle glitches injected on i_ps2_clk during a packet -> they are filtered and the packet decodes correctly. arst asserted mid-byte -> all outputs are 0 and the next packet decodes normally.
